// File: rtl/fazyrv_pkg.sv
// fazyrv_pkg: types and constants shared by the FazyRV instruction-fetch front end.
package fazyrv_pkg;

   typedef enum logic [1:0] {
      IFS_IDLE,
      IFS_DEMAND,
      IFS_PREF,
      IFS_DRAIN
   } ifetch_state_t;

   localparam logic [31:0] FAZYRV_ILLEGAL_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fazyrv_ifetch_buf.sv
// fazyrv_ifetch_buf: one-entry sequential prefetch buffer holding valid, tag, data and error flag.
module fazyrv_ifetch_buf #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fill_i,
   input  logic                  inval_i,
   input  logic [ADDR_WIDTH-1:0] fill_tag_i,
   input  logic [31:0]           fill_data_i,
   input  logic                  fill_err_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   output logic                  hit_o,
   output logic [31:0]           data_o,
   output logic                  err_o
);

   logic                  valid;
   logic [ADDR_WIDTH-1:0] tag;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid  <= 1'b0;
         tag    <= '0;
         data_o <= '0;
         err_o  <= 1'b0;
      end else if (fill_i) begin
         valid  <= 1'b1;
         tag    <= fill_tag_i;
         data_o <= fill_data_i;
         err_o  <= fill_err_i;
      end else if (inval_i) begin
         valid  <= 1'b0;
      end
   end

   assign hit_o = valid & (tag == pc_i);

endmodule

// File: rtl/fazyrv_ifetch.sv
// fazyrv_ifetch: instruction fetch front end on a classic Wishbone read port.
// Define FAZYRV_IFETCH_PREFETCH_EN to add the one-entry sequential prefetch buffer.
module fazyrv_ifetch
   import fazyrv_pkg::*;
#(
   parameter int          ADDR_WIDTH    = 32,
   parameter logic [31:0] ILLEGAL_INSTR = FAZYRV_ILLEGAL_INSTR
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic                  flush_i,
   output logic                  ack_o,
   output logic [31:0]           instr_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i
);

`ifdef FAZYRV_IFETCH_PREFETCH_EN
   localparam bit PREF_EN = 1'b1;
`else
   localparam bit PREF_EN = 1'b0;
`endif

   ifetch_state_t         state, state_n;
   logic                  ack_d, req_v, term, pc_match, take_hit, fwd, start_pref;
   logic                  fill, inval, ack_n, cyc_n;
   logic                  buf_hit, buf_err, unused_sink;
   logic [31:0]           buf_data, instr_n;
   logic [ADDR_WIDTH-1:0] pc_al, adr_n;

   assign pc_al    = {pc_i[ADDR_WIDTH-1:2], 2'b00};
   // the control FSM keeps req_i up through the ack and one more cycle
   assign req_v    = req_i & ~ack_o & ~ack_d;
   assign term     = wb_cyc_o & (wb_ack_i | wb_err_i);
   assign pc_match = pc_al == wb_adr_o;
   assign wb_stb_o = wb_cyc_o;
   assign take_hit = PREF_EN & (state == IFS_IDLE) & req_v & ~flush_i & buf_hit;
   assign fwd      = (state == IFS_PREF) & term & req_v & pc_match & ~flush_i;

`ifdef FAZYRV_IFETCH_PREFETCH_EN
   fazyrv_ifetch_buf #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .fill_i     (fill),
      .inval_i    (inval),
      .fill_tag_i (wb_adr_o),
      .fill_data_i(wb_dat_i),
      .fill_err_i (wb_err_i),
      .pc_i       (pc_al),
      .hit_o      (buf_hit),
      .data_o     (buf_data),
      .err_o      (buf_err)
   );
   assign unused_sink = ^pc_i[1:0];
`else
   assign buf_hit     = 1'b0;
   assign buf_data    = '0;
   assign buf_err     = 1'b0;
   assign unused_sink = ^{fill, inval, pc_i[1:0]};
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state <= IFS_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IFS_IDLE:   state_n = req_v ? (take_hit ? IFS_PREF : IFS_DEMAND) : IFS_IDLE;
         IFS_DEMAND: state_n = term ? (PREF_EN ? IFS_PREF : IFS_IDLE) : IFS_DEMAND;
         IFS_PREF:
            if (!wb_cyc_o)
               state_n = flush_i ? IFS_IDLE : IFS_PREF;
            else if (term)
               state_n = fwd ? IFS_PREF : (req_v ? IFS_DEMAND : IFS_IDLE);
            else
               state_n = (flush_i | (req_v & ~pc_match)) ? IFS_DRAIN : IFS_PREF;
         IFS_DRAIN:  state_n = term ? (req_v ? IFS_DEMAND : IFS_IDLE) : IFS_DRAIN;
         default:    state_n = IFS_IDLE;
      endcase
   end

   always_comb begin
      ack_n      = take_hit | ((state == IFS_DEMAND) & term) | fwd;
      instr_n    = take_hit ? (buf_err ? ILLEGAL_INSTR : buf_data)
                            : (wb_err_i ? ILLEGAL_INSTR : wb_dat_i);
      start_pref = PREF_EN & ack_n;
      fill       = (state == IFS_PREF) & term & ~req_v & ~flush_i;
      inval      = flush_i | take_hit;
      // a freshly started prefetch raises its strobe one cycle after the ack
      cyc_n      = (state_n != IFS_IDLE) & ~start_pref;
      adr_n      = start_pref ? (take_hit ? pc_al : wb_adr_o) + ADDR_WIDTH'(4)
                 : ((state_n == IFS_DEMAND) & (state != IFS_DEMAND)) ? pc_al : wb_adr_o;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_o    <= 1'b0;
         ack_d    <= 1'b0;
         instr_o  <= '0;
         wb_cyc_o <= 1'b0;
         wb_adr_o <= '0;
      end else begin
         ack_o    <= ack_n;
         ack_d    <= ack_o;
         wb_cyc_o <= cyc_n;
         wb_adr_o <= adr_n;
         if (ack_n)
            instr_o <= instr_n;
      end
   end

endmodule

// File: tb/tb_fazyrv_ifetch.sv
// tb_fazyrv_ifetch: directed vector bench for fazyrv_ifetch with a wait-state Wishbone slave.
// Prefetch sequences run when FAZYRV_IFETCH_PREFETCH_EN is defined.
module tb_fazyrv_ifetch;

   logic        clk_i = 1'b0;
   logic        rst_i, req_i, flush_i;
   logic [31:0] pc_i;
   logic        ack_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, term_s;
   logic [31:0] instr_o, wb_adr_o, wb_dat_i;

   int          total = 0;
   int          bad = 0;
   int          ws;
   int          cnt = 0;
   logic [31:0] eadr;

   typedef struct {
      logic [31:0] pc;
      int          ws;
      logic [31:0] eadr;
      logic [31:0] tadr;
      logic [31:0] ins;
      int          lat;
      int          nstb;
   } vec_t;

   fazyrv_ifetch dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .pc_i    (pc_i),
      .flush_i (flush_i),
      .ack_o   (ack_o),
      .instr_o (instr_o),
      .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o),
      .wb_adr_o(wb_adr_o),
      .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : a ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk_i) cnt <= (!wb_cyc_o || term_s) ? 0 : cnt + 1;
   assign term_s   = wb_cyc_o && wb_stb_o && cnt >= ws;
   assign wb_ack_i = term_s && wb_adr_o != eadr;
   assign wb_err_i = term_s && wb_adr_o == eadr;
   assign wb_dat_i = term_s ? mem(wb_adr_o) : 32'hDEAD_BEEF;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] pc, output int lat, output logic [31:0] ins,
                        output logic [31:0] tadr, output int tack, output int nstb, output logic one);
      lat = -1; tack = -1; nstb = 0; ins = '0; tadr = '1; one = 1'b0;
      @(negedge clk_i);
      req_i = 1'b1;
      pc_i  = pc;
      for (int c = 1; c <= 60 && lat < 0; c++) begin
         @(negedge clk_i);
         if (ack_o) begin
            lat = c;
            ins = instr_o;
         end else begin
            nstb += int'(wb_stb_o);
            if (wb_ack_i || wb_err_i) begin
               tack = c;
               tadr = wb_adr_o;
            end
         end
      end
      req_i = 1'b0;
      @(negedge clk_i);
      one = !ack_o;
   endtask

   initial begin
      vec_t        vt[6];
      int          lat, tack, nstb, busy;
      logic [31:0] ins, tadr;
      logic        one;
      vt[0] = '{32'h0000_0100, 0, 32'h1,         32'h0000_0100, 32'h0000_0013, 2, 1};
      vt[1] = '{32'h0000_2000, 3, 32'h1,         32'h0000_2000, 32'h5A5A_2000, 5, 4};
      vt[2] = '{32'h0000_0042, 1, 32'h1,         32'h0000_0040, 32'h5A5A_0040, 3, 2};
      vt[3] = '{32'h0000_0300, 0, 32'h0000_0300, 32'h0000_0300, 32'h0000_0000, 2, 1};
      vt[4] = '{32'h0000_0ABE, 0, 32'h1,         32'h0000_0ABC, 32'h5A5A_0ABC, 2, 1};
      vt[5] = '{32'h8000_0000, 2, 32'h1,         32'h8000_0000, 32'hDA5A_0000, 4, 3};
      rst_i = 1'b1; req_i = 1'b0; flush_i = 1'b0; pc_i = '0; ws = 0; eadr = 32'h1;
      repeat (3) @(negedge clk_i);
      chk("rst_ack", {31'b0, ack_o}, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_cyc", {31'b0, wb_cyc_o}, 0);
      chk("rst_stb", {31'b0, wb_stb_o}, 0);
      chk("rst_adr", wb_adr_o, 0);
      rst_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         repeat (10) @(negedge clk_i);
         ws   = vt[i].ws;
         eadr = vt[i].eadr;
         fetch(vt[i].pc, lat, ins, tadr, tack, nstb, one);
         chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("v%0d_instr", i), ins, vt[i].ins);
         chk($sformatf("v%0d_adr", i), tadr, vt[i].tadr);
         chk($sformatf("v%0d_stb_cycles", i), nstb, vt[i].nstb);
         chk($sformatf("v%0d_ack_after_wback", i), tack + 1, vt[i].lat);
         chk($sformatf("v%0d_ack_one_cycle", i), {31'b0, one}, 1);
      end
      repeat (10) @(negedge clk_i);
      ws = 0; eadr = 32'h1;
`ifdef FAZYRV_IFETCH_PREFETCH_EN
      fetch(32'h100, lat, ins, tadr, tack, nstb, one);
      chk("seq_first_lat", lat, 2);
      chk("pref_stb_after_ack", {31'b0, wb_stb_o}, 1);
      chk("pref_adr", wb_adr_o, 32'h104);
      repeat (5) @(negedge clk_i);
      fetch(32'h104, lat, ins, tadr, tack, nstb, one);
      chk("hit_lat", lat, 1);
      chk("hit_instr", ins, 32'h5A5A_0104);
      chk("hit_no_bus", nstb, 0);
      repeat (10) @(negedge clk_i);
      fetch(32'h100, lat, ins, tadr, tack, nstb, one);
      repeat (10) @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      fetch(32'h104, lat, ins, tadr, tack, nstb, one);
      chk("flush_miss_lat", lat, 2);
      chk("flush_miss_adr", tadr, 32'h104);
      repeat (10) @(negedge clk_i);
      eadr = 32'h300;
      fetch(32'h300, lat, ins, tadr, tack, nstb, one);
      chk("err_instr", ins, 32'h0);
      repeat (10) @(negedge clk_i);
      fetch(32'h304, lat, ins, tadr, tack, nstb, one);
      chk("after_err_hit_lat", lat, 1);
      chk("after_err_hit_instr", ins, 32'h5A5A_0304);
      repeat (10) @(negedge clk_i);
      eadr = 32'h604;
      fetch(32'h600, lat, ins, tadr, tack, nstb, one);
      repeat (10) @(negedge clk_i);
      fetch(32'h604, lat, ins, tadr, tack, nstb, one);
      chk("buf_err_lat", lat, 1);
      chk("buf_err_instr", ins, 32'h0);
      repeat (10) @(negedge clk_i);
      eadr = 32'h1; ws = 3;
      fetch(32'h500, lat, ins, tadr, tack, nstb, one);
      fetch(32'h200, lat, ins, tadr, tack, nstb, one);
      chk("branch_lat", lat, 7);
      chk("branch_instr", ins, 32'h5A5A_0200);
      chk("branch_adr", tadr, 32'h200);
      repeat (10) @(negedge clk_i);
      fetch(32'h504, lat, ins, tadr, tack, nstb, one);
      chk("discarded_pref_lat", lat, 5);
      chk("discarded_pref_instr", ins, 32'h5A5A_0504);
      repeat (10) @(negedge clk_i);
      fetch(32'hFFFF_FFFC, lat, ins, tadr, tack, nstb, one);
      chk("wrap_instr", ins, 32'hA5A5_FFFC);
      chk("wrap_pref_cyc", {31'b0, wb_cyc_o}, 1);
      chk("wrap_pref_adr", wb_adr_o, 32'h0);
`else
      fetch(32'h104, lat, ins, tadr, tack, nstb, one);
      chk("seq_demand_lat", lat, 2);
      chk("seq_demand_instr", ins, 32'h5A5A_0104);
      busy = 0;
      repeat (10) begin
         @(negedge clk_i);
         busy += int'(wb_cyc_o);
      end
      chk("no_bus_between_reqs", busy, 0);
      flush_i = 1'b1;
      fetch(32'h40, lat, ins, tadr, tack, nstb, one);
      flush_i = 1'b0;
      chk("flush_ignored_lat", lat, 2);
      chk("flush_ignored_instr", ins, 32'h5A5A_0040);
      repeat (5) @(negedge clk_i);
      ws = 3;
      req_i = 1'b1;
      pc_i  = 32'hFFFF_FFFC;
      repeat (2) @(negedge clk_i);
      chk("mid_cyc", {31'b0, wb_cyc_o}, 1);
      chk("mid_adr", wb_adr_o, 32'hFFFF_FFFC);
      req_i = 1'b0;
`endif
      #1 rst_i = 1'b1;
      #1;
      chk("async_rst_cyc", {31'b0, wb_cyc_o}, 0);
      chk("async_rst_stb", {31'b0, wb_stb_o}, 0);
      chk("async_rst_adr", wb_adr_o, 0);
      chk("async_rst_ack", {31'b0, ack_o}, 0);
      chk("async_rst_instr", instr_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
